// File: rtl/bitrev_pkg.sv
// Shared definitions for the bit-reversal datapath: word width, assembler
// state encoding and the counter-width helper.
package bitrev_pkg;

  localparam int MAXBITS_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Bits needed to hold any count from 0 up to and including maxbits.
  function automatic int cntw(input int maxbits);
    return $clog2(maxbits + 1);
  endfunction

endpackage

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel front end: shifts bits in MSB-first, closes a frame on
// sin_last or a full word, and holds the result under a valid/ready handshake.
module serial_word_assembler
  import bitrev_pkg::*;
#(
  parameter  int MAXBITS = MAXBITS_DEFAULT,
  localparam int CNTW    = cntw(MAXBITS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sin,
  input  logic               sin_valid,
  input  logic               sin_last,
  output logic               sin_ready,
  output logic [MAXBITS-1:0] out_data,
  output logic [CNTW-1:0]    out_len,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [CNTW-1:0] LAST_COUNT = CNTW'(MAXBITS - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [MAXBITS-1:0] r_shreg;
  logic [CNTW-1:0]    r_count;
  logic               w_accept;
  logic               w_frame_end;
  logic               w_release;

  assign w_accept    = sin_valid & sin_ready;
  // A full word closes the frame even without sin_last, so a last flag on
  // the final bit never spawns an empty frame.
  assign w_frame_end = sin_last | (r_count == LAST_COUNT);
  assign w_release   = (r_state == FULL) & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, SHIFT: begin
        if (w_accept) begin
          w_state_next = w_frame_end ? FULL : SHIFT;
        end
      end
      FULL: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    sin_ready = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE, SHIFT: sin_ready = 1'b1;
      FULL:        out_valid = 1'b1;
      default: begin
        sin_ready = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_shreg <= {r_shreg[MAXBITS-2:0], sin};
      r_count <= r_count + 1'b1;
    end else if (w_release) begin
      r_shreg <= '0;
      r_count <= '0;
    end
  end

  // Clearing on release leaves the word right-aligned with zero padding above.
  assign out_data = r_shreg;
  assign out_len  = r_count;

endmodule

// File: doc/serial_word_assembler.md
Name: serial_word_assembler

Overview:
- Serial-to-parallel front end for the bit-reversal datapath.
- Collects a serial bitstream into a MAXBITS-wide word, first-received bit in the MSB, and presents it with a valid/ready handshake.
- Its out_data drives the `in` port of the combinational bit reverser directly downstream.
- Supports short frames terminated by sin_last, zero-padded at the top, with the received length reported.

Parameters:
- MAXBITS, 32, word width; must match the downstream reverser; legal range ≥ 2.
- CNTW, $clog2(MAXBITS+1), derived localparam; width of the bit counter and out_len.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is valid this cycle.
- sin_last  input  1  final bit of the frame; qualified by sin_valid.
- sin_ready  output  1  block can accept a bit this cycle.
- out_data  output  MAXBITS  assembled word, right-aligned.
- out_len  output  CNTW  number of valid bits in out_data, from 1 to MAXBITS.
- out_valid  output  1  out_data/out_len hold a complete frame.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; shift register=0; count=0.
  - out_data=0, out_len=0, out_valid=0, sin_ready=1 on the following cycle.
  - Applies mid-frame and mid-hold: any partial or unconsumed word is discarded.
- Bit accept: occurs when sin_valid & sin_ready at a clk edge.
  - shreg <= {shreg[MAXBITS-2:0], sin}
  - count <= count+1
  - sin_last is ignored when sin_valid=0.
- States:
  - IDLE: count=0, shreg=0, sin_ready=1.
    - Accept with sin_last=1 → FULL, len=1.
    - Accept with sin_last=0 → SHIFT.
  - SHIFT: sin_ready=1.
    - Accept where count+1==MAXBITS, or sin_last=1 → FULL.
    - Otherwise stay in SHIFT.
    - No timeout; the block waits indefinitely between bits.
  - FULL: out_valid=1, sin_ready=0; out_len = count.
    - out_data/out_len held stable while out_valid & !out_ready.
    - On out_ready=1 → IDLE; shreg and count cleared at the same edge.
- Latency:
  - out_valid rises on the cycle after the accepting edge of the final bit.
  - One bubble cycle after the handshake: no bit is accepted in the cycle out_valid & out_ready completes.
  - Peak throughput: one word per MAXBITS+1 cycles.
- Short frame of N bits:
  - First bit lands at position N-1; bits MAXBITS-1..N are 0; out_len=N.
- Simultaneous events:
  - sin_last on the MAXBITS-th bit gives a single frame of length MAXBITS, not an extra empty frame.
  - sin_valid while sin_ready=0 is not consumed; the source must hold the bit.
- Width: count never exceeds MAXBITS; out_len=MAXBITS is representable because CNTW is sized for MAXBITS+1.

Decomposition:
- Shared package bitrev_pkg holds:
  - the default MAXBITS (32), common to this block and the reverser;
  - state encodings: IDLE=2'd0, SHIFT=2'd1, FULL=2'd2;
  - the CNTW helper.
- No sub-module: the counter and shift register are kept inline.
- The top-level pairs this block with the bit reverser.

Test Plan:
- Reset then full frame: MAXBITS=32; 32 bits sent back-to-back from 0xA5C3_0F81, MSB first; out_ready=1 → out_valid=1 exactly one cycle after bit 32; out_data=0xA5C3_0F81; out_len=32; the reverser output is 0x81F0_C3A5.
- Short frame: bits 1,0,1 with sin_last on the third → out_data=0x0000_0005, out_len=3.
- Backpressure: full frame with out_ready=0 for 5 cycles → out_data stable and sin_ready=0 throughout; on out_ready=1, next cycle is IDLE with sin_ready=1.
- Gapped input: sin_valid toggled 1/0 for 8-bit pattern 0xC6 with sin_last on bit 8 → out_data=0xC6, out_len=8; idle cycles do not shift.
- Reset mid-frame: rst_n=0 after 10 bits → next frame of 32 bits 0xFFFF_FFFF assembles to 0xFFFF_FFFF with no residue from the first frame.
- Boundary: single bit 1 with sin_last in IDLE → out_data=1, out_len=1; back-to-back frames show exactly one bubble cycle.
